sect571k1_pt_mul_if: RTL

- Word-serial host adapter that sits directly upstream and downstream of sect571k1_pt_mul.
- Assembles the 571-bit scalar d from DW-bit input words, then issues a one-cycle start to the multiplier.
- Waits for done, captures the x and y outputs, and streams them back out as DW-bit words with a valid/ready handshake.
- Replaces wide parallel buses so the multiplier can attach to a narrow host or bus fabric.

---
 rtl/sect571k1_pkg.sv | 18 +
 rtl/sect571k1_word_ser.sv | 84 ++++++++
 rtl/sect571k1_pt_mul_if.sv | 111 +++++++++++
 3 files changed

// File: rtl/sect571k1_pkg.sv
// Shared constants, state encoding and sizing helper for the sect571k1 point-multiplier
// host adapter.
package sect571k1_pkg;

  localparam int unsigned M = 571;

  function automatic int unsigned nwords(input int unsigned dw);
    return (M + dw - 1) / dw;
  endfunction

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StStart  = 2'd1,
    StWait   = 2'd2,
    StUnload = 2'd3
  } state_e;

endpackage

// File: rtl/sect571k1_word_ser.sv
// Captures x and y in parallel and streams them out as DW-bit words, x first, with
// valid/ready handshake and a last marker on the final y word.
module sect571k1_word_ser
  import sect571k1_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [M-1:0]  x_i,
  input  logic [M-1:0]  y_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic          done_o
);

  localparam int unsigned NW = nwords(DW);
  localparam int unsigned PW = NW * DW;
  localparam int unsigned CW = $clog2(2 * NW);

  logic [M-1:0]    x_q, x_d, y_q, y_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            active_q, active_d;
  logic [2*PW-1:0] cat;
  logic [DW-1:0]   word_arr [2*NW];

  // Zero padding makes the bits above 570 of each top word read as 0.
  assign cat = {{(PW - M){1'b0}}, y_q, {(PW - M){1'b0}}, x_q};

  always_comb begin
    for (int j = 0; j < 2 * NW; j++) begin
      word_arr[j] = cat[j*DW +: DW];
    end
  end

  assign valid_o = active_q;
  assign last_o  = active_q && (idx_q == CW'(2 * NW - 1));
  assign data_o  = active_q ? word_arr[idx_q] : '0;
  assign done_o  = active_q && ready_i && last_o;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (clr_i) begin
      x_d      = '0;
      y_d      = '0;
      idx_d    = '0;
      active_d = 1'b0;
    end else if (load_i) begin
      x_d      = x_i;
      y_d      = y_i;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (active_q && ready_i) begin
      if (last_o) begin
        idx_d    = '0;
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/sect571k1_pt_mul_if.sv
// Word-serial host adapter for sect571k1_pt_mul: deserializes the scalar, pulses start,
// waits for done and serializes x then y back to the host.
module sect571k1_pt_mul_if
  import sect571k1_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          pm_clr,
  output logic          pm_start,
  output logic [M-1:0]  pm_d,
  input  logic          pm_done,
  input  logic [M-1:0]  pm_x,
  input  logic [M-1:0]  pm_y
);

  localparam int unsigned NW = nwords(DW);
  localparam int unsigned CW = $clog2(2 * NW);
  localparam int unsigned LB = M - (NW - 1) * DW;  // live bits in the top scalar word

  state_e        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [M-1:0]  d_q, d_d;
  logic          ser_load;
  logic          ser_done;

  assign in_ready = (state_q == StLoad);
  assign pm_start = (state_q == StStart);
  assign busy     = (state_q != StLoad);
  assign pm_clr   = clr;
  assign pm_d     = d_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    d_d      = d_q;
    ser_load = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          for (int j = 0; j < NW - 1; j++) begin
            if (k_q == CW'(j)) d_d[j*DW +: DW] = in_data;
          end
          if (k_q == CW'(NW - 1)) begin
            d_d[M-1 -: LB] = in_data[LB-1:0];
            k_d            = '0;
            state_d        = StStart;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (pm_done) begin
          ser_load = 1'b1;
          state_d  = StUnload;
        end
      end
      StUnload: begin
        if (ser_done) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
    if (clr) begin
      state_d  = StLoad;
      k_d      = '0;
      d_d      = '0;
      ser_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      k_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      d_q     <= d_d;
    end
  end

  sect571k1_word_ser #(
    .DW(DW)
  ) u_ser (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .load_i (ser_load),
    .x_i    (pm_x),
    .y_i    (pm_y),
    .valid_o(out_valid),
    .ready_i(out_ready),
    .data_o (out_data),
    .last_o (out_last),
    .done_o (ser_done)
  );

endmodule
